// File: rtl/secret_stim_pkg.sv
// Shared types and helpers for the accumulator stimulus/checker stage.
// Holds the FSM encoding, the LFSR polynomial and the saturating error add.
package secret_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // Galois form, shift right: the bit shifted out folds the taps back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        lfsr_next = (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'h0, inc};
        sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/secret_lfsr32.sv
// 32-bit Galois LFSR register; a zero seed is replaced with 1 so it never locks up.
// Advances only when asked, otherwise holds so consecutive passes continue the sequence.
module secret_lfsr32 import secret_stim_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] value_q;
    logic [31:0] value_d;
    logic [31:0] seed_eff;

    assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;

    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= seed_eff;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/secret_stim_gen.sv
// Stimulus generator and shadow-model checker for the downstream accumulator.
// Optional wide passthrough stimulus/check is enabled by defining SECRET_STIM_WIDE_EN.
module secret_stim_gen import secret_stim_pkg::*; #(
    parameter logic [15:0] NUM_CYCLES = 16'd64,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [15:0]  err_count,
    output logic [31:0]  accum_in,
    output logic         accum_bypass,
    output logic [128:0] s129_in,
    input  logic [31:0]  accum_out,
    input  logic [31:0]  accum_bypass_out,
    input  logic [128:0] s129_out
);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] exp_q, exp_d;
    logic [15:0] err_q, err_d;
    logic [31:0] lfsr;
    logic        lfsr_adv;
    logic [1:0]  miss;

    secret_lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .seed    (SEED),
        .advance (lfsr_adv),
        .value   (lfsr)
    );

`ifdef SECRET_STIM_WIDE_EN
    logic [128:0] wide_stim;
    assign wide_stim = {lfsr[0], lfsr, ~lfsr, lfsr ^ {16'h0, cnt_q}, {16'h0, cnt_q}};
`else
    logic unused_s129;
    assign unused_s129 = ^s129_out;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exp_d        = exp_q;
        err_d        = err_q;
        miss         = 2'd0;
        lfsr_adv     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        accum_in     = 32'h0;
        accum_bypass = 1'b0;
        s129_in      = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SYNC;
            end
            // The accumulator has no reset, so the model adopts whatever it holds.
            SYNC: begin
                busy    = 1'b1;
                exp_d   = accum_out;
                cnt_d   = 16'h0;
                err_d   = 16'h0;
                state_d = RUN;
            end
            RUN: begin
                busy         = 1'b1;
                accum_in     = lfsr;
                accum_bypass = cnt_q[2];
                lfsr_adv     = 1'b1;
                exp_d        = exp_q + lfsr;
                cnt_d        = cnt_q + 16'd1;
                miss         = {1'b0, accum_out != exp_q}
                             + {1'b0, accum_bypass_out != (cnt_q[2] ? lfsr : exp_q)};
`ifdef SECRET_STIM_WIDE_EN
                s129_in      = wide_stim;
                miss         = miss + {1'b0, s129_out != wide_stim};
`endif
                err_d        = sat_add16(err_q, miss);
                if (cnt_q == NUM_CYCLES - 16'd1) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                miss    = {1'b0, accum_out != exp_q};
                err_d   = sat_add16(err_q, miss);
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = SYNC;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'h0;
            exp_q   <= 32'h0;
            err_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
        end
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_secret_stim_gen.sv
// Bench for secret_stim_gen: three instances, each driving a behavioural accumulator
// with fault-injection masks on its returned outputs.
module tb_secret_stim_gen;

`ifdef SECRET_STIM_WIDE_EN
    localparam bit WIDE = 1'b1;
`else
    localparam bit WIDE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Instance A: NUM_CYCLES=4, SEED=1, faults on accum_out and s129_out
    logic         rst_a = 1'b1, start_a = 1'b0, busy_a, done_a, byp_a;
    logic [15:0]  err_a;
    logic [31:0]  ain_a, aout_a, bout_a, axor_a = 32'h0;
    logic [31:0]  acc_a = 32'h12345678;
    logic [128:0] sin_a, sout_a, sxor_a = '0;

    // Instance B: NUM_CYCLES=2, SEED=0
    logic         rst_b = 1'b1, start_b = 1'b0, busy_b, done_b, byp_b;
    logic [15:0]  err_b;
    logic [31:0]  ain_b, aout_b, bout_b;
    logic [31:0]  acc_b = 32'hCAFE0001;
    logic [128:0] sin_b, sout_b;

    // Instance C: NUM_CYCLES=8, SEED=1, faults on accum_out and accum_bypass_out
    logic         rst_c = 1'b1, start_c = 1'b0, busy_c, done_c, byp_c;
    logic [15:0]  err_c;
    logic [31:0]  ain_c, aout_c, bout_c, axor_c = 32'h0, bxor_c = 32'h0;
    logic [31:0]  acc_c = 32'h0F0F1234;
    logic [128:0] sin_c, sout_c;

    always @(posedge clk) acc_a <= acc_a + ain_a;
    always @(posedge clk) acc_b <= acc_b + ain_b;
    always @(posedge clk) acc_c <= acc_c + ain_c;

    assign aout_a = acc_a ^ axor_a;
    assign bout_a = byp_a ? ain_a : acc_a;
    assign sout_a = sin_a ^ sxor_a;
    assign aout_b = acc_b;
    assign bout_b = byp_b ? ain_b : acc_b;
    assign sout_b = sin_b;
    assign aout_c = acc_c ^ axor_c;
    assign bout_c = (byp_c ? ain_c : acc_c) ^ bxor_c;
    assign sout_c = sin_c;

    secret_stim_gen #(.NUM_CYCLES(16'd4), .SEED(32'h1)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .err_count(err_a), .accum_in(ain_a), .accum_bypass(byp_a), .s129_in(sin_a),
        .accum_out(aout_a), .accum_bypass_out(bout_a), .s129_out(sout_a)
    );

    secret_stim_gen #(.NUM_CYCLES(16'd2), .SEED(32'h0)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .err_count(err_b), .accum_in(ain_b), .accum_bypass(byp_b), .s129_in(sin_b),
        .accum_out(aout_b), .accum_bypass_out(bout_b), .s129_out(sout_b)
    );

    secret_stim_gen #(.NUM_CYCLES(16'd8), .SEED(32'h1)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .busy(busy_c), .done(done_c),
        .err_count(err_c), .accum_in(ain_c), .accum_bypass(byp_c), .s129_in(sin_c),
        .accum_out(aout_c), .accum_bypass_out(bout_c), .s129_out(sout_c)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        vectors++;
        if ({busy_a, done_a, byp_a} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000", {busy_a, done_a, byp_a});
        end
        vectors++;
        if (err_a !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_err: got %h want 0000", err_a);
        end
        vectors++;
        if (ain_a !== 32'h0 || sin_a !== 129'h0) begin
            miscompares++;
            $display("FAIL reset_stim: got %h/%h want 0/0", ain_a, sin_a);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        tick();
    endtask

    task automatic test_single_pass;
        logic [31:0] exp_run [4];
        int edges;
        int busy_cycles;
        exp_run = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001};
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        edges = 0;
        busy_cycles = 0;
        for (int i = 0; i < 20 && done_a !== 1'b1; i++) begin
            if (busy_a === 1'b1) busy_cycles++;
            if (i >= 1 && i <= 4) begin
                vectors++;
                if (ain_a !== exp_run[i-1] || byp_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pass1_run%0d: got %h/%b want %h/0", i, ain_a, byp_a, exp_run[i-1]);
                end
            end
            tick();
            edges++;
        end
        vectors++;
        if (edges != 6 || done_a !== 1'b1) begin
            miscompares++;
            $display("FAIL pass1_done_latency: got %0d edges done=%b want 6 edges done=1", edges, done_a);
        end
        vectors++;
        if (busy_cycles != 6) begin
            miscompares++;
            $display("FAIL pass1_busy_len: got %0d want 6", busy_cycles);
        end
        vectors++;
        if (err_a !== 16'h0 || ain_a !== 32'h0 || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL pass1_done_state: got err=%h ain=%h busy=%b want 0/0/0", err_a, ain_a, busy_a);
        end
    endtask

    task automatic test_accum_fault;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        vectors++;
        if (ain_a !== 32'hB02C0003) begin
            miscompares++;
            $display("FAIL pass2_lfsr_continue: got %h want b02c0003", ain_a);
        end
        tick();
        axor_a = 32'h1;
        tick();
        axor_a = 32'h0;
        for (int i = 0; i < 20 && done_a !== 1'b1; i++) tick();
        vectors++;
        if (done_a !== 1'b1 || err_a !== 16'd1) begin
            miscompares++;
            $display("FAIL accum_fault_err: got done=%b err=%0d want done=1 err=1", done_a, err_a);
        end
        tick();
        tick();
        tick();
        vectors++;
        if (done_a !== 1'b1 || err_a !== 16'd1) begin
            miscompares++;
            $display("FAIL done_frozen: got done=%b err=%0d want done=1 err=1", done_a, err_a);
        end
    endtask

    task automatic test_reset_mid_pass;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        vectors++;
        if (busy_a !== 1'b0 || ain_a !== 32'h0 || err_a !== 16'h0) begin
            miscompares++;
            $display("FAIL midrst_idle: got busy=%b ain=%h err=%h want 0/0/0", busy_a, ain_a, err_a);
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        vectors++;
        if (ain_a !== 32'h1) begin
            miscompares++;
            $display("FAIL midrst_reseed: got %h want 00000001", ain_a);
        end
        for (int i = 0; i < 20 && done_a !== 1'b1; i++) tick();
        vectors++;
        if (done_a !== 1'b1 || err_a !== 16'd0) begin
            miscompares++;
            $display("FAIL midrst_err: got done=%b err=%0d want done=1 err=0", done_a, err_a);
        end
    endtask

    task automatic test_wide;
        logic [128:0] exp_wide;
        logic [15:0]  exp_err;
        exp_wide = WIDE ? {1'b1, 32'hB02C0003, 32'h4FD3FFFC, 32'hB02C0003, 32'h0} : 129'h0;
        exp_err  = WIDE ? 16'd1 : 16'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        vectors++;
        if (sin_a !== exp_wide) begin
            miscompares++;
            $display("FAIL wide_stim: got %h want %h", sin_a, exp_wide);
        end
        tick();
        sxor_a = '1;
        tick();
        sxor_a = '0;
        for (int i = 0; i < 20 && done_a !== 1'b1; i++) tick();
        vectors++;
        if (done_a !== 1'b1 || err_a !== exp_err) begin
            miscompares++;
            $display("FAIL wide_err: got done=%b err=%0d want done=1 err=%0d", done_a, err_a, exp_err);
        end
    endtask

    task automatic test_zero_seed;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        vectors++;
        if (busy_b !== 1'b1 || ain_b !== 32'h0) begin
            miscompares++;
            $display("FAIL zseed_sync: got busy=%b ain=%h want 1/0", busy_b, ain_b);
        end
        tick();
        vectors++;
        if (ain_b !== 32'h1) begin
            miscompares++;
            $display("FAIL zseed_run1: got %h want 00000001", ain_b);
        end
        tick();
        vectors++;
        if (ain_b !== 32'h80200003) begin
            miscompares++;
            $display("FAIL zseed_run2: got %h want 80200003", ain_b);
        end
        tick();
        tick();
        vectors++;
        if (done_b !== 1'b1 || err_b !== 16'd0) begin
            miscompares++;
            $display("FAIL zseed_done: got done=%b err=%0d want 1/0", done_b, err_b);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] tbl [6];
        tbl = '{32'hC0300002, 32'h60180001, 32'hB02C0003, 32'hD8360002, 32'h6C1B0001, 32'hB62D8003};
        start_b = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick();
            vectors++;
            if (done_b !== 1'b0 || busy_b !== 1'b1 || ain_b !== 32'h0) begin
                miscompares++;
                $display("FAIL b2b_sync%0d: got done=%b busy=%b ain=%h want 0/1/0", p, done_b, busy_b, ain_b);
            end
            tick();
            vectors++;
            if (ain_b !== tbl[2*p]) begin
                miscompares++;
                $display("FAIL b2b_run%0d_a: got %h want %h", p, ain_b, tbl[2*p]);
            end
            tick();
            vectors++;
            if (ain_b !== tbl[2*p+1]) begin
                miscompares++;
                $display("FAIL b2b_run%0d_b: got %h want %h", p, ain_b, tbl[2*p+1]);
            end
            tick();
            tick();
            vectors++;
            if (done_b !== 1'b1 || err_b !== 16'd0) begin
                miscompares++;
                $display("FAIL b2b_done%0d: got done=%b err=%0d want 1/0", p, done_b, err_b);
            end
        end
        start_b = 1'b0;
        tick();
    endtask

    task automatic test_bypass;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (byp_c !== (k >= 4)) begin
                miscompares++;
                $display("FAIL bypass_sel%0d: got %b want %b", k, byp_c, (k >= 4));
            end
            if (k == 1 || k == 5 || k == 6) bxor_c = 32'h00000100;
            if (k == 6) axor_c = 32'h80000000;
            tick();
            bxor_c = 32'h0;
            axor_c = 32'h0;
        end
        for (int i = 0; i < 20 && done_c !== 1'b1; i++) tick();
        vectors++;
        if (done_c !== 1'b1 || busy_c !== 1'b0 || err_c !== 16'd4) begin
            miscompares++;
            $display("FAIL bypass_err: got done=%b busy=%b err=%0d want 1/0/4", done_c, busy_c, err_c);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_accum_fault();
        test_reset_mid_pass();
        test_wide();
        test_zero_seed();
        test_back_to_back();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
